// File: rtl/cycle_counter.sv
// -----------------------------------------------------------------------------
// cycle_counter
//
// Purpose:
//   Accumulates single-cycle increment pulses into a packed-BCD count during a
//   measurement window. start_i opens the window and stop_i closes it. On close
//   the final count is latched into result_o and valid_o strobes for one cycle.
//   overflow_o is sticky and records an increment taken at full scale
//   (all digits 9).
//
// Configuration:
//   CYCLE_COUNTER_SATURATE_EN - when defined, a full-scale increment holds the
//                               count at all-9s. When undefined (the default),
//                               the count wraps to zero. Both builds set
//                               overflow_o.
//
// Parameters:
//   DIGITS       number of BCD digits (full scale is 10^DIGITS - 1)
//
// Ports:
//   clk_i        in   1         sole clock, rising edge
//   rst_i        in   1         synchronous active-high reset
//   start_i      in   1         open or restart a window
//   stop_i       in   1         close the window and latch the result
//   increment_i  in   1         adds one to the count while counting
//   count_o      out  4*DIGITS  running BCD count, digit 0 in bits [3:0]
//   result_o     out  4*DIGITS  BCD count latched at the last stop
//   valid_o      out  1         one-cycle strobe when result_o updates
//   overflow_o   out  1         sticky full-scale overflow flag
//   busy_o       out  1         high while a window is open
// -----------------------------------------------------------------------------
module cycle_counter #(
    parameter int DIGITS = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  increment_i,
    output logic [4*DIGITS-1:0]   count_o,
    output logic [4*DIGITS-1:0]   result_o,
    output logic                  valid_o,
    output logic                  overflow_o,
    output logic                  busy_o
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t         state;
    logic [W-1:0]   count_plus1;
    logic [W-1:0]   inc_value;
    logic           at_full;

    // Ripple-carry BCD increment. A digit at 9 rolls to 0 and passes the carry
    // upward, so the all-9s value naturally wraps to all zeros.
    function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] value);
        logic [W-1:0] res;
        logic         carry;
        res   = value;
        carry = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (value[4*i +: 4] == 4'd9) begin
                    res[4*i +: 4] = 4'd0;
                end else begin
                    res[4*i +: 4] = value[4*i +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
        return res;
    endfunction

    function automatic logic is_full(input logic [W-1:0] value);
        logic full;
        full = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (value[4*i +: 4] != 4'd9) begin
                full = 1'b0;
            end
        end
        return full;
    endfunction

    always_comb begin
        count_plus1 = bcd_inc(count_o);
        at_full     = is_full(count_o);
`ifdef CYCLE_COUNTER_SATURATE_EN
        inc_value   = at_full ? count_o : count_plus1;
`else
        inc_value   = count_plus1;
`endif
    end

    // Window state machine. Inside COUNTING, stop has priority over start, and
    // a restart discards any increment arriving in the same cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            count_o    <= '0;
            result_o   <= '0;
            valid_o    <= 1'b0;
            overflow_o <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            case (state)
                COUNTING: begin
                    if (stop_i) begin
                        state   <= DONE;
                        busy_o  <= 1'b0;
                        valid_o <= 1'b1;
                        if (increment_i) begin
                            count_o  <= inc_value;
                            result_o <= inc_value;
                            if (at_full) begin
                                overflow_o <= 1'b1;
                            end
                        end else begin
                            result_o <= count_o;
                        end
                    end else if (start_i) begin
                        count_o    <= '0;
                        overflow_o <= 1'b0;
                    end else if (increment_i) begin
                        count_o <= inc_value;
                        if (at_full) begin
                            overflow_o <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (start_i) begin
                        state      <= COUNTING;
                        busy_o     <= 1'b1;
                        count_o    <= '0;
                        overflow_o <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cycle_counter.sv
// -----------------------------------------------------------------------------
// tb_cycle_counter
//
// Purpose:
//   Self-checking bench for cycle_counter with DIGITS = 3. It combines a table
//   of directed vectors, hand-written multi-cycle sequences and random
//   stimulus. All of these are checked against a reference model that holds
//   the count as a plain integer and converts it to BCD with division.
// -----------------------------------------------------------------------------
module tb_cycle_counter;

    localparam int DIGITS = 3;
    localparam int W      = 4 * DIGITS;
    localparam int FULL   = 999;

    logic           clk_i = 1'b0;
    logic           rst_i = 1'b0;
    logic           start_i = 1'b0;
    logic           stop_i = 1'b0;
    logic           increment_i = 1'b0;
    logic [W-1:0]   count_o;
    logic [W-1:0]   result_o;
    logic           valid_o;
    logic           overflow_o;
    logic           busy_o;

    int checks = 0;
    int errors = 0;

    // Reference model state: 0 idle, 1 counting, 2 done
    int m_state  = 0;
    int m_count  = 0;
    int m_result = 0;
    bit m_valid  = 0;
    bit m_ovf    = 0;

    typedef struct {
        logic         rst;
        logic         start;
        logic         stop;
        logic         inc;
        logic [W-1:0] exp_count;
        logic [W-1:0] exp_result;
        logic         exp_valid;
        logic         exp_ovf;
        logic         exp_busy;
    } vec_t;

    vec_t vecs[12];

    cycle_counter #(.DIGITS(DIGITS)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .stop_i      (stop_i),
        .increment_i (increment_i),
        .count_o     (count_o),
        .result_o    (result_o),
        .valid_o     (valid_o),
        .overflow_o  (overflow_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r;
        r[3:0]  = 4'(v % 10);
        r[7:4]  = 4'((v / 10) % 10);
        r[11:8] = 4'((v / 100) % 10);
        return r;
    endfunction

    function automatic vec_t mk(input logic rst, input logic start, input logic stop,
                                input logic inc, input logic [W-1:0] c, input logic [W-1:0] r,
                                input logic v, input logic o, input logic b);
        vec_t x;
        x.rst = rst; x.start = start; x.stop = stop; x.inc = inc;
        x.exp_count = c; x.exp_result = r; x.exp_valid = v; x.exp_ovf = o; x.exp_busy = b;
        return x;
    endfunction

    task automatic model_inc();
        if (m_count == FULL) begin
            m_ovf = 1;
`ifdef CYCLE_COUNTER_SATURATE_EN
            m_count = FULL;
`else
            m_count = 0;
`endif
        end else begin
            m_count = m_count + 1;
        end
    endtask

    task automatic model_step(input bit rst, input bit start, input bit stop, input bit inc);
        if (rst) begin
            m_state = 0; m_count = 0; m_result = 0; m_valid = 0; m_ovf = 0;
        end else begin
            m_valid = 0;
            if (m_state == 1) begin
                if (stop) begin
                    if (inc) model_inc();
                    m_result = m_count;
                    m_valid  = 1;
                    m_state  = 2;
                end else if (start) begin
                    m_count = 0;
                    m_ovf   = 0;
                end else if (inc) begin
                    model_inc();
                end
            end else if (start) begin
                m_count = 0;
                m_ovf   = 0;
                m_state = 1;
            end
        end
    endtask

    // Drives one cycle of inputs, advances the model at the edge and leaves
    // the bench 1 time unit after the edge, ready to sample.
    task automatic applyStimulus(input bit rst, input bit start, input bit stop, input bit inc);
        rst_i = rst; start_i = start; stop_i = stop; increment_i = inc;
        @(posedge clk_i);
        model_step(rst, start, stop, inc);
        #1;
    endtask

    task automatic checkValue(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkValue({tag, " count"},    count_o,  to_bcd(m_count));
        checkValue({tag, " result"},   result_o, to_bcd(m_result));
        checkValue({tag, " valid"},    W'(valid_o),    W'(m_valid));
        checkValue({tag, " overflow"}, W'(overflow_o), W'(m_ovf));
        checkValue({tag, " busy"},     W'(busy_o),     W'(m_state == 1));
    endtask

    task automatic run_incs(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput(tag);
        end
    endtask

    initial begin
        // Reset for two cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1, 1'($urandom), 1'($urandom), 1'($urandom));
        end
        checkOutput("reset");
        applyStimulus(0, 0, 1, 1);
        checkOutput("idle ignore");
        applyStimulus(0, 0, 0, 1);
        checkOutput("idle ignore2");

        // Directed vector table: basic window, DONE behaviour, start+stop
        vecs[0]  = mk(0, 1, 0, 0, 12'h000, 12'h000, 0, 0, 1);
        vecs[1]  = mk(0, 0, 0, 1, 12'h001, 12'h000, 0, 0, 1);
        vecs[2]  = mk(0, 0, 0, 1, 12'h002, 12'h000, 0, 0, 1);
        vecs[3]  = mk(0, 0, 0, 1, 12'h003, 12'h000, 0, 0, 1);
        vecs[4]  = mk(0, 0, 0, 1, 12'h004, 12'h000, 0, 0, 1);
        vecs[5]  = mk(0, 0, 0, 1, 12'h005, 12'h000, 0, 0, 1);
        vecs[6]  = mk(0, 0, 1, 0, 12'h005, 12'h005, 1, 0, 0);
        vecs[7]  = mk(0, 0, 0, 0, 12'h005, 12'h005, 0, 0, 0);
        vecs[8]  = mk(0, 0, 0, 1, 12'h005, 12'h005, 0, 0, 0);
        vecs[9]  = mk(0, 0, 1, 0, 12'h005, 12'h005, 0, 0, 0);
        vecs[10] = mk(0, 1, 0, 1, 12'h000, 12'h005, 0, 0, 1);
        vecs[11] = mk(0, 1, 1, 0, 12'h000, 12'h000, 1, 0, 0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].inc);
            checkValue($sformatf("vec%0d count", i),  count_o,  vecs[i].exp_count);
            checkValue($sformatf("vec%0d result", i), result_o, vecs[i].exp_result);
            checkValue($sformatf("vec%0d valid", i),  W'(valid_o),    W'(vecs[i].exp_valid));
            checkValue($sformatf("vec%0d ovf", i),    W'(overflow_o), W'(vecs[i].exp_ovf));
            checkValue($sformatf("vec%0d busy", i),   W'(busy_o),     W'(vecs[i].exp_busy));
        end

        // 41 increments then increment together with stop
        applyStimulus(0, 1, 0, 0);
        run_incs(41, "inc41");
        applyStimulus(0, 0, 1, 1);
        checkValue("stop+inc result", result_o, 12'h042);
        checkValue("stop+inc valid", W'(valid_o), W'(1'b1));
        checkOutput("stop+inc");

        // Full decade carries and overflow within one window
        applyStimulus(0, 1, 0, 0);
        for (int n = 1; n <= 1000; n++) begin
            applyStimulus(0, 0, 0, 1);
            checkOutput("carry");
            if (n == 9)   checkValue("count 9",   count_o, 12'h009);
            if (n == 10)  checkValue("count 10",  count_o, 12'h010);
            if (n == 99)  checkValue("count 99",  count_o, 12'h099);
            if (n == 100) checkValue("count 100", count_o, 12'h100);
            if (n == 999) checkValue("ovf before", W'(overflow_o), W'(1'b0));
        end
`ifdef CYCLE_COUNTER_SATURATE_EN
        checkValue("full-scale count", count_o, 12'h999);
`else
        checkValue("full-scale count", count_o, 12'h000);
`endif
        checkValue("full-scale ovf", W'(overflow_o), W'(1'b1));
        applyStimulus(0, 0, 0, 1);
        checkOutput("after ovf");
        applyStimulus(0, 1, 0, 0);
        checkValue("start clears ovf", W'(overflow_o), W'(1'b0));
        checkOutput("start clears");

        // Restart mid-window: close a window first to get a known result
        run_incs(3, "pre");
        applyStimulus(0, 0, 1, 0);
        applyStimulus(0, 1, 0, 0);
        run_incs(7, "restart incs");
        applyStimulus(0, 1, 0, 1);
        checkValue("restart count", count_o, 12'h000);
        checkValue("restart busy", W'(busy_o), W'(1'b1));
        checkValue("restart result", result_o, 12'h003);
        checkOutput("restart");

        // Reset mid-window
        run_incs(30, "pre reset");
        applyStimulus(1, 0, 1, 1);
        checkValue("rst count", count_o, 12'h000);
        checkValue("rst busy", W'(busy_o), W'(1'b0));
        checkValue("rst valid", W'(valid_o), W'(1'b0));
        checkOutput("rst mid");
        applyStimulus(0, 0, 1, 1);
        checkValue("rst no valid", W'(valid_o), W'(1'b0));
        checkOutput("post rst");

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(($urandom_range(0, 39) == 0), ($urandom_range(0, 19) == 0),
                          ($urandom_range(0, 14) == 0), 1'($urandom));
            checkOutput("random");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cycle_counter.md
# cycle_counter

Downstream consumer of the pulse counter's `increment` output in the voltmeter FSM bench. It accumulates increment pulses into a DIGITS-wide packed-BCD cycle count during a measurement window opened by `start_i` and closed by `stop_i`. On close it latches the final count into a result register, emits a one-cycle valid strobe and reports overflow. The measurement state machine drives the start and stop controls and reads the result for display.

## Interface
- `DIGITS`, default 3: number of BCD digits; full-scale count is 10^DIGITS − 1 (999 at default).
- `clk_i`  in  1  sole clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, synchronous and active-high.
- `start_i`  in  1  open a window: clear count and overflow, enter COUNTING.
- `stop_i`  in  1  close the window: latch the count, strobe `valid_o`, enter DONE.
- `increment_i`  in  1  single-cycle pulse from the pulse counter; adds 1 while COUNTING.
- `count_o`  out  4*DIGITS  running BCD count; digit 0 in bits [3:0].
- `result_o`  out  4*DIGITS  BCD count latched at the last stop.
- `valid_o`  out  1  one-cycle strobe when `result_o` updates.
- `overflow_o`  out  1  sticky; set when an increment occurs at full-scale; cleared by `start_i` or reset.
- `busy_o`  out  1  high while in COUNTING.

## Operation
- States:
  - IDLE is the reset state.
  - COUNTING accumulates increments.
  - DONE holds the result.
- Transitions:
  - IDLE or DONE, `start_i` → COUNTING. `count_o` and `overflow_o` clear to 0.
  - COUNTING, `stop_i` → DONE. `result_o` ← next count value, which includes any increment in the same cycle. `valid_o` = 1 for one cycle.
  - COUNTING, `start_i` without `stop_i` → restart: count and overflow clear, stay in COUNTING. An increment in that cycle is discarded.
  - COUNTING, `start_i` and `stop_i` together: stop wins, consistent with the pulse counter's stop-over-trigger priority.
  - IDLE or DONE: `stop_i` and `increment_i` are ignored. `count_o` holds its value and `result_o` is unchanged.
- Arithmetic:
  - BCD increment with ripple carry. A digit at 9 becomes 0 and carries into the next digit.
  - Every digit must stay within 0–9 at all times.
  - Increment at full-scale (all digits 9): the count wraps to all-zero and `overflow_o` is set (see Configuration).
  - `increment_i` held high counts once per cycle. No edge detection is performed.
- `result_o` retains its value across windows until the next stop. `start_i` does not clear it.

## Timing
- All outputs are registered.
- Reset values: `count_o` = 0, `result_o` = 0, `valid_o` = 0, `overflow_o` = 0, `busy_o` = 0. State = IDLE.
- `increment_i` at edge N → `count_o` reflects it after edge N, i.e. visible in cycle N+1.
- `stop_i` at edge N → `result_o`, `valid_o` = 1, and `busy_o` = 0 all visible in cycle N+1. `valid_o` returns to 0 in cycle N+2 unless a new stop is accepted.
- `start_i` at edge N → `busy_o` = 1 and `count_o` = 0 in cycle N+1.
- `rst_i` high at any edge forces all reset values in the next cycle, mid-window included, and overrides every other input. A window in progress is abandoned and no `valid_o` is emitted.

## Configuration
- `CYCLE_COUNTER_SATURATE_EN`
  - Defined: a full-scale increment holds the count at all-9s and sets `overflow_o`.
  - Undefined (default): the count wraps to 0 and sets `overflow_o`.
  - All other behaviour is identical in both builds.

## Test plan
All scenarios use DIGITS = 3.
- Reset: assert `rst_i` for 2 cycles with random inputs → all outputs 0, `busy_o` = 0. `stop_i` and `increment_i` afterwards have no effect.
- Basic window: `start_i`, then 5 `increment_i` pulses, then `stop_i` → `count_o` = 12'h005, `result_o` = 12'h005 one cycle after stop, `valid_o` high exactly one cycle, `busy_o` low.
- Simultaneous events:
  - 41 increments, then `increment_i` + `stop_i` in the same cycle → `result_o` = 12'h042.
  - `start_i` + `stop_i` together while counting → stop wins, DONE.
- Decimal carry and overflow: 1000 increments in one window → 12'h009 → 12'h010 at the 10th, 12'h099 → 12'h100 at the 100th. The 1000th gives `count_o` = 12'h000 and `overflow_o` = 1 (12'h999 with `CYCLE_COUNTER_SATURATE_EN`). The next `start_i` clears `overflow_o`.
- Restart mid-window: 7 increments, then `start_i` with `increment_i` high → `count_o` = 0, `busy_o` stays 1, `result_o` keeps its prior value.
- Reset mid-window: 30 increments, then `rst_i` → next cycle `count_o` = 0, state IDLE, `valid_o` never pulses.
